// File: rtl/scandoubler_rotate_arb.sv
// -----------------------------------------------------------------------------
// scandoubler_rotate_arb
//
// Shares one SDRAM burst port between the rotating scandoubler's pixel-write
// stream (vidin_*) and its row-fetch stream (vidout_*). Whole bursts are
// granted; per-word acks from the SDRAM controller are forwarded to whichever
// side owns the current burst. The SDRAM address is {frame, row, col} with the
// column aligned down to the burst size.
//
// Writes have priority. While a read is pending, at most MAX_WR_RUN write
// bursts are granted back to back before the read is served.
//
// Ports
//   clk_sys                 system clock
//   reset_n                 asynchronous active-low reset
//   vidin_req/frame/row/col write burst request and address
//   vidin_d                 write data (passed straight to mem_wdata)
//   vidin_ack               write word accepted
//   vidout_req/frame/row/col read request and address
//   vidout_d, vidout_ack    read word and its valid strobe
//   mem_req, mem_we         burst request / direction to the SDRAM controller
//   mem_addr                {frame, row, burst-aligned col}
//   mem_wdata, mem_rdata    data to / from the SDRAM controller
//   mem_ack                 one word transferred
//   arb_err                 sticky watchdog error
//
// Optional feature: define ARB_WATCHDOG_EN to abort a burst that sees no
// mem_ack for TIMEOUT cycles and flag arb_err. Without it arb_err is 0 and a
// burst waits for acks indefinitely.
// -----------------------------------------------------------------------------
module scandoubler_rotate_arb #(
    parameter int WR_BURST   = 8,
    parameter int RD_BURST   = 8,
    parameter int ROW_BITS   = 11,
    parameter int COL_BITS   = 11,
    parameter int MAX_WR_RUN = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         vidin_req,
    input  logic [1:0]                   vidin_frame,
    input  logic [ROW_BITS-1:0]          vidin_row,
    input  logic [COL_BITS-1:0]          vidin_col,
    input  logic [15:0]                  vidin_d,
    output logic                         vidin_ack,
    input  logic                         vidout_req,
    input  logic [1:0]                   vidout_frame,
    input  logic [ROW_BITS-1:0]          vidout_row,
    input  logic [COL_BITS-1:0]          vidout_col,
    output logic [15:0]                  vidout_d,
    output logic                         vidout_ack,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [2+ROW_BITS+COL_BITS-1:0] mem_addr,
    output logic [15:0]                  mem_wdata,
    input  logic [15:0]                  mem_rdata,
    input  logic                         mem_ack,
    output logic                         arb_err
);

    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int MAXB  = (WR_BURST > RD_BURST) ? WR_BURST : RD_BURST;
    localparam int CW    = (MAXB > 2) ? $clog2(MAXB) : 1;
    localparam int RUNW  = (MAX_WR_RUN > 1) ? $clog2(MAX_WR_RUN + 1) : 1;
    localparam logic [COL_BITS-1:0] WR_COL_MASK = ~(COL_BITS'(WR_BURST - 1));
    localparam logic [COL_BITS-1:0] RD_COL_MASK = ~(COL_BITS'(RD_BURST - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_r, state_next_s;
    logic            req_wr_r, req_rd_r;
    logic            mem_req_r, mem_we_r;
    logic [AW-1:0]   mem_addr_r;
    logic [CW-1:0]   word_cnt_r;
    logic [RUNW-1:0] run_cnt_r;
    logic            grant_wr_s, grant_rd_s, in_burst_s, last_s, timeout_s;

    // Writes win unless a read has waited through MAX_WR_RUN write bursts.
    assign grant_wr_s = (state_r == S_IDLE) && req_wr_r &&
                        !(req_rd_r && (run_cnt_r == RUNW'(MAX_WR_RUN)));
    assign grant_rd_s = (state_r == S_IDLE) && req_rd_r && !grant_wr_s;
    assign in_burst_s = (state_r == S_WR) || (state_r == S_RD);
    assign last_s     = in_burst_s && mem_ack &&
                        (word_cnt_r == ((state_r == S_WR) ? CW'(WR_BURST - 1)
                                                          : CW'(RD_BURST - 1)));

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = vidin_d;

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt_r;
    logic           arb_err_r;

    assign timeout_s = in_burst_s && !mem_ack && (wd_cnt_r == WDW'(TIMEOUT - 1));
    assign arb_err   = arb_err_r;

    // Watchdog: counts ack-less cycles inside a burst; error flag is sticky.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r  <= '0;
            arb_err_r <= 1'b0;
        end else begin
            if (grant_wr_s || grant_rd_s || mem_ack || !in_burst_s) begin
                wd_cnt_r <= '0;
            end else begin
                wd_cnt_r <= wd_cnt_r + WDW'(1);
            end
            arb_err_r <= arb_err_r | timeout_s;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign arb_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; GAP is a single settling cycle after each burst.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_wr_s) begin
                    state_next_s = S_WR;
                end else if (grant_rd_s) begin
                    state_next_s = S_RD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WR, S_RD: begin
                if (last_s || timeout_s) begin
                    state_next_s = S_GAP;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_GAP:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM outputs: acks and read data are forwarded combinationally to the burst owner.
    always_comb begin
        vidin_ack  = 1'b0;
        vidout_ack = 1'b0;
        vidout_d   = 16'd0;
        case (state_r)
            S_WR: vidin_ack = mem_ack;
            S_RD: begin
                vidout_ack = mem_ack;
                vidout_d   = mem_rdata;
            end
            default: begin
                vidin_ack  = 1'b0;
                vidout_ack = 1'b0;
                vidout_d   = 16'd0;
            end
        endcase
    end

    // Datapath: request sampling, address latch, word and run counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_wr_r   <= 1'b0;
            req_rd_r   <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            word_cnt_r <= '0;
            run_cnt_r  <= '0;
        end else begin
            req_wr_r <= vidin_req;
            req_rd_r <= vidout_req;
            if (grant_wr_s) begin
                mem_req_r  <= 1'b1;
                mem_we_r   <= 1'b1;
                mem_addr_r <= {vidin_frame, vidin_row, vidin_col & WR_COL_MASK};
                word_cnt_r <= '0;
                // Only writes that overtake a pending read count toward the run limit.
                if (!req_rd_r) begin
                    run_cnt_r <= '0;
                end else if (run_cnt_r == RUNW'(MAX_WR_RUN)) begin
                    run_cnt_r <= run_cnt_r;
                end else begin
                    run_cnt_r <= run_cnt_r + RUNW'(1);
                end
            end else if (grant_rd_s) begin
                mem_req_r  <= 1'b1;
                mem_we_r   <= 1'b0;
                mem_addr_r <= {vidout_frame, vidout_row, vidout_col & RD_COL_MASK};
                word_cnt_r <= '0;
                run_cnt_r  <= '0;
            end else if (last_s || timeout_s) begin
                mem_req_r  <= 1'b0;
                mem_we_r   <= 1'b0;
                word_cnt_r <= '0;
            end else if (in_burst_s && mem_ack) begin
                word_cnt_r <= word_cnt_r + CW'(1);
            end else if ((state_r == S_IDLE) && !req_rd_r) begin
                run_cnt_r <= '0;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

endmodule
